// File: rtl/axis_bram_frame_writer_if.sv
// AXI-Stream beat channel carrying one FFT input frame from the DMA into the frame writer.
interface axis_bram_frame_writer_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                    tvalid;
  logic                    tlast;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tready;

  modport master (
    output tvalid,
    output tlast,
    output tdata,
    output tkeep,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    input  tkeep,
    output tready
  );
endinterface

// File: rtl/axis_bram_frame_writer.sv
// Writes one FFT input frame per go into a round-robin BRAM bank, in natural or bit-reversed order,
// with tlast framing checks, a registered write port and a done pulse carrying the finished bank.
module axis_bram_frame_writer #(
  parameter int DATA_WIDTH = 64,
  parameter int LOG2_FFT   = 12,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic                    bitrev_en,
  output logic                    busy,
  output logic                    done,
  output logic [BANK_W-1:0]       done_bank,
  output logic                    err_early_tlast,
  output logic                    err_missing_tlast,
  output logic                    mem_we,
  output logic [BANK_W-1:0]       mem_bank,
  output logic [LOG2_FFT-1:0]     mem_waddr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  axis_bram_frame_writer_if.slave s_axis
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [LOG2_FFT-1:0] LAST_IDX = {LOG2_FFT{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  function automatic logic [LOG2_FFT-1:0] bit_reverse(input logic [LOG2_FFT-1:0] value);
    logic [LOG2_FFT-1:0] result;
    result = {LOG2_FFT{1'b0}};
    for (int i = 0; i < LOG2_FFT; i++) begin
      result[i] = value[LOG2_FFT-1-i];
    end
    return result;
  endfunction

  // A single bank never advances; otherwise the power-of-2 width makes the increment wrap.
  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] bank);
    logic [BANK_W-1:0] result;
    if (NUM_BANKS == 1) begin
      result = {BANK_W{1'b0}};
    end else begin
      result = bank + BANK_W'(1);
    end
    return result;
  endfunction

  state_e              state_q, state_d;
  logic [LOG2_FFT-1:0] count_q, count_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                bitrev_q, bitrev_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BANK_W-1:0]   done_bank_q, done_bank_d;
  logic                err_early_q, err_early_d;
  logic                err_missing_q, err_missing_d;
  logic                tready_q, tready_d;
  logic                mem_we_q, mem_we_d;
  logic [BANK_W-1:0]   mem_bank_q, mem_bank_d;
  logic [LOG2_FFT-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

  logic beat_acc;
  logic final_beat;
  logic frame_end;
  logic go_acc;

  // done_q blocks go in the done cycle so a new frame can only start one cycle later.
  always_comb begin
    beat_acc   = s_axis.tvalid & tready_q & (state_q == ST_WRITE);
    final_beat = (count_q == LAST_IDX);
    frame_end  = beat_acc & (final_beat | s_axis.tlast);
    go_acc     = (state_q == ST_IDLE) & go & ~done_q;
  end

  // Frame sequencing, framing checks and the registered write port.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    bank_d        = bank_q;
    bitrev_d      = bitrev_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    done_bank_d   = done_bank_q;
    err_early_d   = err_early_q;
    err_missing_d = err_missing_q;
    tready_d      = tready_q;
    mem_we_d      = 1'b0;
    mem_bank_d    = mem_bank_q;
    mem_waddr_d   = mem_waddr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;

    case (state_q)
      ST_IDLE: begin
        if (go_acc) begin
          state_d       = ST_WRITE;
          bitrev_d      = bitrev_en;
          err_early_d   = 1'b0;
          err_missing_d = 1'b0;
          count_d       = {LOG2_FFT{1'b0}};
          busy_d        = 1'b1;
          tready_d      = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          tready_d = 1'b0;
        end
      end

      ST_WRITE: begin
        if (beat_acc) begin
          mem_we_d    = 1'b1;
          mem_bank_d  = bank_q;
          mem_waddr_d = bitrev_q ? bit_reverse(count_q) : count_q;
          mem_wdata_d = s_axis.tdata;
          mem_wstrb_d = s_axis.tkeep;
          if (frame_end) begin
            // Error-terminated frames still release their bank to the FFT.
            state_d       = ST_IDLE;
            done_d        = 1'b1;
            done_bank_d   = bank_q;
            bank_d        = next_bank(bank_q);
            busy_d        = 1'b0;
            tready_d      = 1'b0;
            err_early_d   = err_early_q | (s_axis.tlast & ~final_beat);
            err_missing_d = err_missing_q | (final_beat & ~s_axis.tlast);
          end else begin
            count_d = count_q + LOG2_FFT'(1);
          end
        end else begin
          state_d = ST_WRITE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        tready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      count_q       <= {LOG2_FFT{1'b0}};
      bank_q        <= {BANK_W{1'b0}};
      bitrev_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      done_bank_q   <= {BANK_W{1'b0}};
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
      tready_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_bank_q    <= {BANK_W{1'b0}};
      mem_waddr_q   <= {LOG2_FFT{1'b0}};
      mem_wdata_q   <= {DATA_WIDTH{1'b0}};
      mem_wstrb_q   <= {STRB_W{1'b0}};
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      bank_q        <= bank_d;
      bitrev_q      <= bitrev_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      done_bank_q   <= done_bank_d;
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
      tready_q      <= tready_d;
      mem_we_q      <= mem_we_d;
      mem_bank_q    <= mem_bank_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign done_bank         = done_bank_q;
  assign err_early_tlast   = err_early_q;
  assign err_missing_tlast = err_missing_q;
  assign mem_we            = mem_we_q;
  assign mem_bank          = mem_bank_q;
  assign mem_waddr         = mem_waddr_q;
  assign mem_wdata         = mem_wdata_q;
  assign mem_wstrb         = mem_wstrb_q;
  assign s_axis.tready     = tready_q;

endmodule

// File: tb/tb_axis_bram_frame_writer.sv
// Directed bench for axis_bram_frame_writer with an 8-beat frame and two banks.
module tb_axis_bram_frame_writer;

  localparam int DW = 64;
  localparam int L2 = 3;
  localparam int NB = 2;
  localparam int BW = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic          bitrev_en;
  logic          busy;
  logic          done;
  logic [BW-1:0] done_bank;
  logic          err_early_tlast;
  logic          err_missing_tlast;
  logic          mem_we;
  logic [BW-1:0] mem_bank;
  logic [L2-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wstrb;

  axis_bram_frame_writer_if #(.DATA_WIDTH(DW)) s_axis ();

  axis_bram_frame_writer #(
    .DATA_WIDTH(DW), .LOG2_FFT(L2), .NUM_BANKS(NB), .BANK_W(BW)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .bitrev_en(bitrev_en),
    .busy(busy), .done(done), .done_bank(done_bank),
    .err_early_tlast(err_early_tlast), .err_missing_tlast(err_missing_tlast),
    .mem_we(mem_we), .mem_bank(mem_bank), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .s_axis(s_axis)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [L2-1:0] cap_addr[$];
  logic [DW-1:0] cap_data[$];
  logic [BW-1:0] cap_bank[$];
  logic [7:0]    cap_strb[$];
  int            done_cnt = 0;
  logic [BW-1:0] last_done_bank = 1'b0;

  logic [L2-1:0] br_tab [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  // Log every BRAM write and done pulse mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      cap_addr.push_back(mem_waddr);
      cap_data.push_back(mem_wdata);
      cap_bank.push_back(mem_bank);
      cap_strb.push_back(mem_wstrb);
    end
    if (done) begin
      done_cnt       <= done_cnt + 1;
      last_done_bank <= done_bank;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic start_frame(input logic br);
    go = 1'b1;
    bitrev_en = br;
    cyc(1);
    go = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [7:0] keep,
                           input int budget, output bit acc);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    s_axis.tlast  = last;
    s_axis.tkeep  = keep;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (s_axis.tready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic run_frame(input logic br);
    bit acc;
    start_frame(br);
    for (int i = 0; i < 8; i++) begin
      send_beat(64'hB0 + 64'(i), i == 7, 8'hFF, 10, acc);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL run_frame_accept beat %0d got %0b want 1", i, acc); end
    end
    cyc(2);
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    cyc(1);
    checks++;
    if ({busy, done, done_bank, err_early_tlast, err_missing_tlast, mem_we, mem_bank,
         mem_waddr, mem_wstrb, s_axis.tready} !== 18'd0 || mem_wdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b done=%0b we=%0b tready=%0b waddr=%0d want all 0",
               busy, done, mem_we, s_axis.tready, mem_waddr);
    end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_bitrev();
    int base;
    int dbase;
    bit acc;
    base  = cap_addr.size();
    dbase = done_cnt;
    start_frame(1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %0b want 1", busy); end
    for (int i = 0; i < 8; i++) begin
      send_beat(64'hA0 + 64'(i), i == 7, 8'hFF, 10, acc);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL t1_accept beat %0d got %0b want 1", i, acc); end
    end
    checks++;
    if ({done, done_bank, busy} !== 3'b100) begin
      errors++;
      $display("FAIL t1_done_cycle got done=%0b bank=%0b busy=%0b want 1 0 0", done, done_bank, busy);
    end
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    cyc(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t1_go_with_done got busy=%0b want 0", busy); end
    checks++;
    if (cap_addr.size() - base !== 8) begin
      errors++; $display("FAIL t1_writes got %0d want 8", cap_addr.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (cap_addr[base+i] !== br_tab[i] || cap_data[base+i] !== 64'hA0 + 64'(i) || cap_bank[base+i] !== 1'b0) begin
          errors++;
          $display("FAIL t1_write %0d got addr=%0d data=%h bank=%0b want addr=%0d data=%h bank=0",
                   i, cap_addr[base+i], cap_data[base+i], cap_bank[base+i], br_tab[i], 64'hA0 + 64'(i));
        end
      end
    end
    checks++;
    if (done_cnt - dbase !== 1 || err_early_tlast !== 1'b0 || err_missing_tlast !== 1'b0) begin
      errors++;
      $display("FAIL t1_done_err got dones=%0d early=%0b missing=%0b want 1 0 0",
               done_cnt - dbase, err_early_tlast, err_missing_tlast);
    end
  endtask

  task automatic test_banks();
    int base;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      base = cap_addr.size();
      run_frame(1'b0);
      checks++;
      if (cap_addr.size() - base !== 8) begin
        errors++; $display("FAIL t2_writes frame %0d got %0d want 8", f, cap_addr.size() - base);
      end else begin
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (cap_addr[base+i] !== 3'(i) || cap_bank[base+i] !== 1'(f % 2)) begin
            errors++;
            $display("FAIL t2_write frame %0d beat %0d got addr=%0d bank=%0b want addr=%0d bank=%0d",
                     f, i, cap_addr[base+i], cap_bank[base+i], i, f % 2);
          end
        end
      end
      checks++;
      if (last_done_bank !== 1'(f % 2)) begin
        errors++; $display("FAIL t2_done_bank frame %0d got %0b want %0d", f, last_done_bank, f % 2);
      end
    end
  endtask

  task automatic test_gaps();
    int base;
    bit acc;
    int gaps [8] = '{1, 3, 5, 2, 4, 1, 5, 3};
    do_reset();
    base = cap_addr.size();
    start_frame(1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(gaps[i]);
      checks++;
      if (cap_addr.size() - base !== i) begin
        errors++; $display("FAIL t3_gap_writes before beat %0d got %0d want %0d", i, cap_addr.size() - base, i);
      end
      send_beat(64'hC0 + 64'(i), i == 7, 8'hFF, 10, acc);
    end
    cyc(2);
    checks++;
    if (cap_addr.size() - base !== 8) begin
      errors++; $display("FAIL t3_writes got %0d want 8", cap_addr.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (cap_addr[base+i] !== 3'(i) || cap_data[base+i] !== 64'hC0 + 64'(i)) begin
          errors++;
          $display("FAIL t3_write %0d got addr=%0d data=%h want addr=%0d data=%h",
                   i, cap_addr[base+i], cap_data[base+i], i, 64'hC0 + 64'(i));
        end
      end
    end
  endtask

  task automatic test_early_tlast();
    int base;
    int dbase;
    bit acc;
    do_reset();
    base  = cap_addr.size();
    dbase = done_cnt;
    start_frame(1'b0);
    for (int i = 0; i < 4; i++) send_beat(64'hD0 + 64'(i), i == 3, 8'hFF, 10, acc);
    checks++;
    if ({done, err_early_tlast, err_missing_tlast} !== 3'b110) begin
      errors++;
      $display("FAIL t4_end got done=%0b early=%0b missing=%0b want 1 1 0", done, err_early_tlast, err_missing_tlast);
    end
    cyc(2);
    checks++;
    if (s_axis.tready !== 1'b0 || cap_addr.size() - base !== 4 || done_cnt - dbase !== 1) begin
      errors++;
      $display("FAIL t4_after got tready=%0b writes=%0d dones=%0d want 0 4 1",
               s_axis.tready, cap_addr.size() - base, done_cnt - dbase);
    end
    base = cap_addr.size();
    start_frame(1'b0);
    checks++;
    if (err_early_tlast !== 1'b0) begin errors++; $display("FAIL t4_clear got %0b want 0", err_early_tlast); end
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        go = 1'b1;
        cyc(1);
        go = 1'b0;
      end
      send_beat(64'hE0 + 64'(i), i == 7, (i < 2) ? 8'hFF : 8'h0F, 10, acc);
    end
    cyc(2);
    checks++;
    if (cap_addr.size() - base !== 8) begin
      errors++; $display("FAIL t4_go_in_write writes got %0d want 8", cap_addr.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (cap_addr[base+i] !== 3'(i) || cap_strb[base+i] !== ((i < 2) ? 8'hFF : 8'h0F)) begin
          errors++;
          $display("FAIL t4_strb %0d got addr=%0d strb=%h want addr=%0d strb=%h",
                   i, cap_addr[base+i], cap_strb[base+i], i, (i < 2) ? 8'hFF : 8'h0F);
        end
      end
    end
  endtask

  task automatic test_missing_tlast();
    int base;
    int dbase;
    bit acc;
    do_reset();
    base  = cap_addr.size();
    dbase = done_cnt;
    start_frame(1'b0);
    for (int i = 0; i < 8; i++) send_beat(64'hF0 + 64'(i), 1'b0, 8'hFF, 10, acc);
    checks++;
    if ({done, err_missing_tlast, err_early_tlast} !== 3'b110) begin
      errors++;
      $display("FAIL t5_end got done=%0b missing=%0b early=%0b want 1 1 0", done, err_missing_tlast, err_early_tlast);
    end
    send_beat(64'hF8, 1'b1, 8'hFF, 6, acc);
    checks++;
    if (acc !== 1'b0) begin errors++; $display("FAIL t5_ninth got accepted=%0b want 0", acc); end
    checks++;
    if (cap_addr.size() - base !== 8 || done_cnt - dbase !== 1 || err_missing_tlast !== 1'b1) begin
      errors++;
      $display("FAIL t5_after got writes=%0d dones=%0d missing=%0b want 8 1 1",
               cap_addr.size() - base, done_cnt - dbase, err_missing_tlast);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    int dbase;
    bit acc;
    do_reset();
    run_frame(1'b0);
    dbase = done_cnt;
    start_frame(1'b1);
    for (int i = 0; i < 4; i++) send_beat(64'h10 + 64'(i), 1'b0, 8'hFF, 10, acc);
    reset = 1'b1;
    cyc(1);
    checks++;
    if ({busy, done, done_bank, mem_we, mem_bank, mem_waddr, s_axis.tready} !== 9'd0) begin
      errors++;
      $display("FAIL t6_reset got busy=%0b done=%0b we=%0b bank=%0b waddr=%0d tready=%0b want all 0",
               busy, done, mem_we, mem_bank, mem_waddr, s_axis.tready);
    end
    reset = 1'b0;
    cyc(2);
    checks++;
    if (done_cnt !== dbase) begin errors++; $display("FAIL t6_no_done got %0d want %0d", done_cnt, dbase); end
    base = cap_addr.size();
    run_frame(1'b0);
    checks++;
    if (cap_addr.size() - base !== 8 || cap_addr[base] !== 3'd0 || cap_bank[base] !== 1'b0) begin
      errors++;
      $display("FAIL t6_restart got writes=%0d addr=%0d bank=%0b want 8 0 0",
               cap_addr.size() - base, cap_addr[base], cap_bank[base]);
    end
  endtask

  initial begin
    reset = 1'b1;
    go = 1'b0;
    bitrev_en = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    s_axis.tdata = 64'd0;
    s_axis.tkeep = 8'h00;
    test_reset();
    test_bitrev();
    test_banks();
    test_gaps();
    test_early_tlast();
    test_missing_tlast();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
